// File: rtl/demux_stream_sched_if.sv
// Stream-side bundle for the 1-to-4 demux scheduler: one valid/ready input
// stream, four independent valid/ready output channels, and status.
interface demux_stream_sched_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic               mode;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_sel;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [4*WIDTH-1:0] out_data;
   logic [1:0]         last_sel;
   logic [CNT_W-1:0]   xfer_cnt;

   // Source/sink side (drives the input stream and the sink readies)
   modport master (
      output mode, in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, last_sel, xfer_cnt
   );

   // Scheduler side
   modport slave (
      input  mode, in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, last_sel, xfer_cnt
   );
endinterface

// File: rtl/demux_stream_sched.sv
// Sequencing controller for the 1-to-4 demux datapath. Each input word goes to
// the channel picked by in_sel (addressed) or a rotating pointer (round-robin).
// Every channel owns a one-entry output register, so backpressure is applied
// per channel and nothing is dropped.
module demux_stream_sched #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   demux_stream_sched_if.slave  bus
);

   logic [1:0]       rr_ptr_reg;
   logic [1:0]       last_sel_reg;
   logic [CNT_W-1:0] xfer_cnt_reg;
   logic [1:0]       target;
   logic [3:0]       free;
   logic [3:0]       load;
   logic             accept;

   // The target must not look at in_valid so that in_ready stays a pure
   // function of the selection and the channel occupancy.
   assign target       = bus.mode ? rr_ptr_reg : bus.in_sel;
   assign bus.in_ready = free[target];
   assign accept       = bus.in_valid && free[target];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_ch
         logic             valid_reg;
         logic [WIDTH-1:0] data_reg;

         // A slot is free when empty or when its content leaves this edge
         assign free[gi] = !valid_reg || bus.out_ready[gi];
         assign load[gi] = accept && (target == 2'(gi));

         // Channel register: a load beats a drain; data is kept after a drain
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
            end else if (load[gi]) begin
               valid_reg <= 1'b1;
               data_reg  <= bus.in_data;
            end else if (bus.out_ready[gi]) begin
               valid_reg <= 1'b0;
            end
         end

         assign bus.out_valid[gi]                  = valid_reg;
         assign bus.out_data[gi*WIDTH +: WIDTH]    = data_reg;
      end
   endgenerate

   // Pointer, last destination and transfer count move only on an accept;
   // the pointer steps only in round-robin mode and never skips a channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg   <= 2'd0;
         last_sel_reg <= 2'd0;
         xfer_cnt_reg <= '0;
      end else if (accept) begin
         last_sel_reg <= target;
         xfer_cnt_reg <= xfer_cnt_reg + CNT_W'(1);
         if (bus.mode) begin
            rr_ptr_reg <= rr_ptr_reg + 2'd1;
         end
      end
   end

   assign bus.last_sel = last_sel_reg;
   assign bus.xfer_cnt = xfer_cnt_reg;

endmodule
